pim_dma_cmd_queue: RTL and testbench

//  Command queue between the core's PIM custom-instruction decode and pim_dma. Buffers up to

---
 rtl/pim_dma_cmd_queue.sv | 170 +++++++++++++++++
 tb/tb_pim_dma_cmd_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_dma_cmd_queue.sv
// Command queue between PIM custom-instruction decode and pim_dma.
// Validates commands, buffers them and issues one at a time while the DMA is idle.
module pim_dma_cmd_queue #(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       cmd_valid_i,
    output logic                       cmd_ready_o,
    input  logic [2:0]                 cmd_funct3_i,
    input  logic [3:0]                 cmd_sel_pim_i,
    input  logic [12:0]                cmd_size_i,
    input  logic [31:0]                cmd_addr_i,
    output logic                       dma_en_o,
    output logic [2:0]                 dma_funct3_o,
    output logic [3:0]                 dma_sel_pim_o,
    output logic [12:0]                dma_size_o,
    output logic [31:0]                dma_addr_o,
    input  logic                       dma_busy_i,
    output logic [$clog2(DEPTH+1)-1:0] queue_count_o,
    output logic                       idle_o,
    output logic                       err_o,
    input  logic                       err_clr_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(BUSY_TIMEOUT+1);

    typedef struct packed {
        logic [2:0]  funct3;
        logic [3:0]  sel_pim;
        logic [12:0] size;
        logic [31:0] addr;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    cmd_t            mem [DEPTH];
    cmd_t            incoming;
    cmd_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    state_t          state;
    logic [TW-1:0]   timer;

    logic            full;
    logic            empty;
    logic            legal;
    logic            accept;
    logic            push;
    logic            bad_push;
    logic            pop;
    logic            timeout;

    assign incoming = '{
        funct3:  cmd_funct3_i,
        sel_pim: cmd_sel_pim_i,
        size:    cmd_size_i,
        addr:    cmd_addr_i
    };
    assign head = mem[rd_ptr];

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // 000 and 011 are not PIM operations
    assign legal = (cmd_funct3_i != 3'b000) &&
                   (cmd_funct3_i != 3'b011) &&
                   (cmd_size_i != '0) &&
                   (cmd_addr_i[1:0] == 2'b00);

    assign accept   = cmd_valid_i && cmd_ready_o;
    assign push     = accept && legal;
    assign bad_push = accept && !legal;
    assign pop      = (state == IDLE) && !empty && !dma_busy_i;
    assign timeout  = (state == WAIT_BUSY) && !dma_busy_i &&
                      (timer == TW'(BUSY_TIMEOUT-1));

    assign cmd_ready_o   = !full;
    assign queue_count_o = count;
    assign idle_o        = empty && (state == IDLE) && !dma_busy_i;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= incoming;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (err_clr_i) begin
            err_o <= 1'b0;
        end else if (bad_push || timeout) begin
            err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            timer         <= '0;
            dma_en_o      <= 1'b0;
            dma_funct3_o  <= '0;
            dma_sel_pim_o <= '0;
            dma_size_o    <= '0;
            dma_addr_o    <= '0;
        end else begin
            dma_en_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        dma_funct3_o  <= head.funct3;
                        dma_sel_pim_o <= head.sel_pim;
                        dma_size_o    <= head.size;
                        dma_addr_o    <= head.addr;
                        dma_en_o      <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (dma_busy_i) begin
                        state <= WAIT_DONE;
                    end else if (timeout) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!dma_busy_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pim_dma_cmd_queue.sv
// Directed bench for pim_dma_cmd_queue with a behavioural pim_dma model
// and a scoreboard of expected issued commands.
module tb_pim_dma_cmd_queue;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_funct3 = '0;
    logic [3:0]  cmd_sel_pim = '0;
    logic [12:0] cmd_size = '0;
    logic [31:0] cmd_addr = '0;
    logic        dma_en;
    logic [2:0]  dma_funct3;
    logic [3:0]  dma_sel_pim;
    logic [12:0] dma_size;
    logic [31:0] dma_addr;
    logic        dma_busy = 1'b0;
    logic [2:0]  queue_count;
    logic        idle;
    logic        err;
    logic        err_clr = 1'b0;

    int          nerr = 0;
    int          nchk = 0;
    int          issues = 0;
    logic [51:0] exp_q[$];

    logic        hold_busy = 1'b0;
    bit          never_busy = 1'b0;
    int          busy_len = 6;
    int          busy_cnt = 0;
    logic        prev_en = 1'b0;

    pim_dma_cmd_queue #(.DEPTH(4), .BUSY_TIMEOUT(15)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_funct3_i (cmd_funct3),
        .cmd_sel_pim_i(cmd_sel_pim),
        .cmd_size_i   (cmd_size),
        .cmd_addr_i   (cmd_addr),
        .dma_en_o     (dma_en),
        .dma_funct3_o (dma_funct3),
        .dma_sel_pim_o(dma_sel_pim),
        .dma_size_o   (dma_size),
        .dma_addr_o   (dma_addr),
        .dma_busy_i   (dma_busy),
        .queue_count_o(queue_count),
        .idle_o       (idle),
        .err_o        (err),
        .err_clr_i    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor first, then the DMA model reacts to the strobe.
    always @(negedge clk) begin
        logic [51:0] e;
        if (dma_en) begin
            issues++;
            check("en_while_busy", {63'd0, dma_busy}, 64'd0);
            check("en_pulse_width", {63'd0, prev_en}, 64'd0);
            check("issue_expected", {63'd0, exp_q.size() != 0}, 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("issue_cmd",
                      {12'd0, dma_funct3, dma_sel_pim, dma_size, dma_addr},
                      {12'd0, e});
            end
        end
        prev_en = dma_en;
        if (dma_en && !never_busy) busy_cnt = busy_len;
        else if (busy_cnt > 0) busy_cnt--;
        dma_busy = hold_busy || (busy_cnt > 0);
    end

    task automatic push_cmd(input logic [2:0] f, input logic [3:0] s,
                            input logic [12:0] sz, input logic [31:0] a,
                            input int max_wait);
        bit done = 0;
        bit ok;
        ok = (f != 3'b000) && (f != 3'b011) && (sz != 0) && (a[1:0] == 2'b00);
        cmd_valid = 1'b1;
        cmd_funct3 = f;
        cmd_sel_pim = s;
        cmd_size = sz;
        cmd_addr = a;
        for (int i = 0; i < max_wait && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                if (ok) exp_q.push_back({f, s, sz, a});
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        check("push_accept", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_idle(input string tag, input int max_wait);
        for (int i = 0; i < max_wait; i++) begin
            if (idle && exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(tag, {63'd0, idle}, 64'd1);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic wait_en(input string tag, input int max_wait);
        for (int i = 0; i < max_wait; i++) begin
            if (dma_en) break;
            @(posedge clk);
            #1;
        end
        check(tag, {63'd0, dma_en}, 64'd1);
    endtask

    initial begin
        int n0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", {63'd0, cmd_ready}, 64'd1);
        check("rst_idle", {63'd0, idle}, 64'd1);
        check("rst_count", queue_count, 0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_en", {63'd0, dma_en}, 64'd0);
        check("rst_addr", dma_addr, 0);

        // single command, two-cycle issue latency
        busy_len = 6;
        push_cmd(3'b010, 4'd3, 13'd4, 32'h100, 5);
        check("lat_en_early", {63'd0, dma_en}, 64'd0);
        check("lat_count", queue_count, 1);
        @(posedge clk);
        #1;
        check("lat_en", {63'd0, dma_en}, 64'd1);
        check("lat_count_pop", queue_count, 0);
        @(posedge clk);
        #1;
        check("en_one_cycle", {63'd0, dma_en}, 64'd0);
        check("busy_not_idle", {63'd0, idle}, 64'd0);
        wait_idle("t1_idle", 40);
        check("t1_hold", {dma_funct3, dma_sel_pim, dma_size, dma_addr},
              {3'b010, 4'd3, 13'd4, 32'h100});

        // fill queue while DMA is busy, then release
        hold_busy = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        push_cmd(3'b001, 4'd1, 13'd8, 32'h200, 5);
        push_cmd(3'b100, 4'd2, 13'd16, 32'h204, 5);
        push_cmd(3'b101, 4'd4, 13'd1, 32'h208, 5);
        push_cmd(3'b110, 4'd5, 13'd2, 32'h20c, 5);
        check("full_ready", {63'd0, cmd_ready}, 64'd0);
        check("full_count", queue_count, 4);
        cmd_valid = 1'b1;
        cmd_funct3 = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("stall_count", queue_count, 4);
        check("stall_no_issue", {63'd0, dma_en}, 64'd0);
        hold_busy = 1'b0;
        push_cmd(3'b111, 4'd6, 13'd3, 32'h210, 20);
        wait_idle("t2_idle", 200);

        // illegal commands and error clear
        n0 = issues;
        push_cmd(3'b011, 4'd1, 13'd4, 32'h300, 5);
        check("bad_f3_err", {63'd0, err}, 64'd1);
        push_cmd(3'b010, 4'd1, 13'd0, 32'h300, 5);
        push_cmd(3'b010, 4'd1, 13'd4, 32'h302, 5);
        check("bad_count", queue_count, 0);
        repeat (4) @(posedge clk);
        #1;
        check("bad_no_issue", issues, n0);
        check("bad_err", {63'd0, err}, 64'd1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_err", {63'd0, err}, 64'd0);
        push_cmd(3'b000, 4'd1, 13'd4, 32'h300, 5);
        err_clr = 1'b0;
        check("clr_wins", {63'd0, err}, 64'd0);

        // busy never rises: timeout then next command still issues
        never_busy = 1'b1;
        push_cmd(3'b010, 4'd7, 13'd5, 32'h400, 5);
        push_cmd(3'b001, 4'd8, 13'd6, 32'h404, 5);
        wait_en("to_first_en", 10);
        repeat (15) @(posedge clk);
        #1;
        check("to_err_early", {63'd0, err}, 64'd0);
        @(posedge clk);
        #1;
        check("to_err", {63'd0, err}, 64'd1);
        @(posedge clk);
        #1;
        check("to_next_en", {63'd0, dma_en}, 64'd1);
        never_busy = 1'b0;
        wait_idle("t4_idle", 60);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;

        // simultaneous push and pop at count 2
        hold_busy = 1'b1;
        busy_len = 2;
        @(negedge clk);
        @(posedge clk);
        #1;
        push_cmd(3'b100, 4'd1, 13'd10, 32'h500, 5);
        push_cmd(3'b101, 4'd2, 13'd11, 32'h504, 5);
        check("pp_count_pre", queue_count, 2);
        hold_busy = 1'b0;
        push_cmd(3'b110, 4'd3, 13'd12, 32'h508, 5);
        check("pp_count", queue_count, 2);
        for (int i = 0; i < 9; i++) begin
            push_cmd(3'b010, 4'(i), 13'(20 + i), 32'h600 + 32'(4 * i), 40);
        end
        wait_idle("wrap_idle", 300);
        check("wrap_err", {63'd0, err}, 64'd0);

        // reset during WAIT_DONE with three queued
        busy_len = 30;
        push_cmd(3'b001, 4'd1, 13'd1, 32'h700, 5);
        push_cmd(3'b001, 4'd2, 13'd2, 32'h704, 5);
        push_cmd(3'b001, 4'd3, 13'd3, 32'h708, 5);
        push_cmd(3'b001, 4'd4, 13'd4, 32'h70c, 5);
        repeat (2) @(posedge clk);
        #1;
        check("mid_count", queue_count, 3);
        check("mid_busy", {63'd0, dma_busy}, 64'd1);
        rst_ni = 1'b0;
        #1;
        check("arst_count", queue_count, 0);
        check("arst_en", {63'd0, dma_en}, 64'd0);
        check("arst_ready", {63'd0, cmd_ready}, 64'd1);
        exp_q.delete();
        busy_cnt = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", {63'd0, idle}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_no_en", {63'd0, dma_en}, 64'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
